// File: rtl/pose_recorder.sv
// pose_recorder: samples x/y/z servo positions every SAMPLE_DIV cycles into a 3-channel RAM
// that playback reads by address. Build option POSE_REC_LOOP_EN: circular recording at depth.
module pose_recorder #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 8,
    parameter int SAMPLE_DIV    = 2500000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rec_en,
    input  logic                     clear,
    input  logic [15:0]              data_x,
    input  logic [15:0]              data_y,
    input  logic [15:0]              data_z,
    input  logic [ADDRESS_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]    rd_data_x,
    output logic [DATA_WIDTH-1:0]    rd_data_y,
    output logic [DATA_WIDTH-1:0]    rd_data_z,
    output logic                     rd_valid,
    output logic [ADDRESS_WIDTH:0]   length,
    output logic                     recording,
    output logic                     full,
    output logic                     wr_strobe
);
    localparam int CNT_W = $clog2(SAMPLE_DIV);
    localparam logic [CNT_W-1:0]       TICK_RELOAD = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [ADDRESS_WIDTH:0] LEN_MAX     = {1'b1, {ADDRESS_WIDTH{1'b0}}};
    localparam logic [15:0]            SAT_MAX     = 16'((32'd1 << DATA_WIDTH) - 1);

    // IDLE | stopped, take retained   RECORD | sampling   FULL | depth reached, no writes
    typedef enum logic [1:0] {IDLE, RECORD, FULL} state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         tick_q, tick_d;
    logic [ADDRESS_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [ADDRESS_WIDTH:0]   length_q, length_d;
    logic                     rec_prev_q;
    logic                     wr_strobe_q, wr_strobe_d;
    logic [DATA_WIDTH-1:0]    rd_data_x_q, rd_data_x_d;
    logic [DATA_WIDTH-1:0]    rd_data_y_q, rd_data_y_d;
    logic [DATA_WIDTH-1:0]    rd_data_z_q, rd_data_z_d;
    logic                     rd_valid_q, rd_valid_d;
    logic                     rec_rise;
    logic                     do_write;

    logic [DATA_WIDTH-1:0] mem_x [0:(1<<ADDRESS_WIDTH)-1];
    logic [DATA_WIDTH-1:0] mem_y [0:(1<<ADDRESS_WIDTH)-1];
    logic [DATA_WIDTH-1:0] mem_z [0:(1<<ADDRESS_WIDTH)-1];

    function automatic logic [DATA_WIDTH-1:0] sat(input logic [15:0] v);
        return (v > SAT_MAX) ? '1 : v[DATA_WIDTH-1:0];
    endfunction

    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        wr_addr_d   = wr_addr_q;
        length_d    = length_q;
        do_write    = 1'b0;
        rec_rise    = rec_en && !rec_prev_q;
        case (state_q)
            IDLE: begin
                if (rec_rise) begin
                    state_d   = RECORD;
                    tick_d    = TICK_RELOAD;
                    wr_addr_d = '0;
                    length_d  = '0;
                end else if (clear) begin
                    wr_addr_d = '0;
                    length_d  = '0;
                end
            end
            RECORD: begin
                if (!rec_en) begin
                    state_d = IDLE;
                end else if (tick_q == '0) begin
                    do_write  = 1'b1;
                    tick_d    = TICK_RELOAD;
                    wr_addr_d = wr_addr_q + 1'b1;
`ifdef POSE_REC_LOOP_EN
                    if (length_q != LEN_MAX) length_d = length_q + 1'b1;
`else
                    length_d = length_q + 1'b1;
                    if (length_q == LEN_MAX - 1'b1) state_d = FULL;
`endif
                end else begin
                    tick_d = tick_q - 1'b1;
                end
            end
            FULL: begin
                if (clear) begin
                    state_d   = IDLE;
                    wr_addr_d = '0;
                    length_d  = '0;
                end else if (!rec_en) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        wr_strobe_d = do_write;
        rd_data_x_d = mem_x[rd_addr];
        rd_data_y_d = mem_y[rd_addr];
        rd_data_z_d = mem_z[rd_addr];
        rd_valid_d  = {1'b0, rd_addr} < length_q;
    end

    // rec_prev resets high so a level held through reset cannot look like a fresh edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            tick_q      <= '0;
            wr_addr_q   <= '0;
            length_q    <= '0;
            rec_prev_q  <= 1'b1;
            wr_strobe_q <= 1'b0;
            rd_data_x_q <= '0;
            rd_data_y_q <= '0;
            rd_data_z_q <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            wr_addr_q   <= wr_addr_d;
            length_q    <= length_d;
            rec_prev_q  <= rec_en;
            wr_strobe_q <= wr_strobe_d;
            rd_data_x_q <= rd_data_x_d;
            rd_data_y_q <= rd_data_y_d;
            rd_data_z_q <= rd_data_z_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && do_write) begin
            mem_x[wr_addr_q] <= sat(data_x);
            mem_y[wr_addr_q] <= sat(data_y);
            mem_z[wr_addr_q] <= sat(data_z);
        end
    end

    assign rd_data_x = rd_data_x_q;
    assign rd_data_y = rd_data_y_q;
    assign rd_data_z = rd_data_z_q;
    assign rd_valid  = rd_valid_q;
    assign length    = length_q;
    assign recording = (state_q == RECORD);
    assign full      = (length_q == LEN_MAX);
    assign wr_strobe = wr_strobe_q;
endmodule

// File: tb/tb_pose_recorder.sv
// Directed bench for pose_recorder with a read scoreboard and a small RAM/length model.
`timescale 1ns/1ps
module tb_pose_recorder;
    localparam int DW = 8;
    localparam int AW = 3;
    localparam int SD = 4;
    localparam int DEPTH = 8;
`ifdef POSE_REC_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rec_en = 1'b0;
    logic          clear = 1'b0;
    logic [15:0]   data_x = '0, data_y = '0, data_z = '0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data_x, rd_data_y, rd_data_z;
    logic          rd_valid, recording, full, wr_strobe;
    logic [AW:0]   length;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string         tag;
        logic          valid;
        logic          chk_data;
        logic [DW-1:0] x, y, z;
    } rd_exp_t;
    rd_exp_t sb[$];

    logic [DW-1:0] mx [DEPTH];
    logic [DW-1:0] my [DEPTH];
    logic [DW-1:0] mz [DEPTH];
    int exp_len = 0;
    int waddr = 0;

    pose_recorder #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .SAMPLE_DIV(SD)) dut (
        .clk(clk), .rst(rst), .rec_en(rec_en), .clear(clear),
        .data_x(data_x), .data_y(data_y), .data_z(data_z),
        .rd_addr(rd_addr), .rd_data_x(rd_data_x), .rd_data_y(rd_data_y), .rd_data_z(rd_data_z),
        .rd_valid(rd_valid), .length(length), .recording(recording), .full(full),
        .wr_strobe(wr_strobe)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] sat(input logic [15:0] v);
        return (v > 16'd255) ? 8'hFF : v[7:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_start();
        waddr = 0;
        exp_len = 0;
    endtask

    task automatic model_write(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        mx[waddr] = sat(x);
        my[waddr] = sat(y);
        mz[waddr] = sat(z);
        waddr = (waddr + 1) % DEPTH;
        if (exp_len < DEPTH) exp_len++;
    endtask

    task automatic push_rd(input string tag, input logic valid, input logic chk_data,
                           input logic [DW-1:0] x, input logic [DW-1:0] y, input logic [DW-1:0] z);
        rd_exp_t e;
        e.tag = tag;
        e.valid = valid;
        e.chk_data = chk_data;
        e.x = x;
        e.y = y;
        e.z = z;
        sb.push_back(e);
    endtask

    task automatic pop_rd();
        rd_exp_t e;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL sb_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_valid"}, rd_valid, e.valid);
            if (e.chk_data) begin
                chk({e.tag, "_x"}, rd_data_x, e.x);
                chk({e.tag, "_y"}, rd_data_y, e.y);
                chk({e.tag, "_z"}, rd_data_z, e.z);
            end
        end
    endtask

    task automatic do_read(input string tag, input int a);
        rd_addr = AW'(a);
        push_rd(tag, a < exp_len, a < exp_len, mx[a], my[a], mz[a]);
        step();
        pop_rd();
    endtask

    initial begin
        logic se;
        int   nw;

        // reset state
        rst = 1'b0;
        step();
        step();
        chk("rst_length", length, 0);
        chk("rst_full", full, 0);
        chk("rst_recording", recording, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_x", rd_data_x, 0);
        chk("rst_rd_y", rd_data_y, 0);
        chk("rst_rd_z", rd_data_z, 0);
        chk("rst_strobe", wr_strobe, 0);
        rst = 1'b1;
        step();

        // three samples of a constant pose
        data_x = 16'd10; data_y = 16'd20; data_z = 16'd30;
        rec_en = 1'b1;
        model_start();
        for (int k = 1; k <= 13; k++) begin
            step();
            se = (k >= 5) && ((k - 5) % 4 == 0);
            if (se) model_write(data_x, data_y, data_z);
            chk("t2_strobe", wr_strobe, se);
            chk("t2_recording", recording, 1);
            chk("t2_length", length, exp_len);
        end
        rec_en = 1'b0;
        step();
        chk("t2_stop_recording", recording, 0);
        chk("t2_stop_length", length, 3);
        do_read("t2_rd2", 2);
        do_read("t2_rd3", 3);

        // saturation boundaries
        data_x = 16'h0123; data_y = 16'h00FF; data_z = 16'h0100;
        rec_en = 1'b1;
        model_start();
        for (int k = 1; k <= 5; k++) begin
            step();
            se = (k == 5);
            if (se) model_write(data_x, data_y, data_z);
            chk("t3_strobe", wr_strobe, se);
        end
        rec_en = 1'b0;
        step();
        chk("t3_length", length, 1);
        do_read("t3_rd0", 0);
        do_read("t3_rd1", 1);

        // fill to depth with a changing pose
        rec_en = 1'b1;
        model_start();
        nw = 0;
        for (int k = 1; k <= 41; k++) begin
            data_x = 16'(k * 7);
            data_y = 16'(250 + k);
            data_z = 16'(k * k);
            step();
            se = (k >= 5) && ((k - 5) % 4 == 0) && (LOOP || nw < DEPTH);
            if (se) begin
                model_write(data_x, data_y, data_z);
                nw++;
            end
            chk("t4_strobe", wr_strobe, se);
            chk("t4_length", length, exp_len);
            chk("t4_full", full, exp_len == DEPTH);
            chk("t4_recording", recording, LOOP || nw < DEPTH);
        end
        if (LOOP) begin
            rec_en = 1'b0;
            step();
            chk("t4_loop_stop", recording, 0);
        end
        for (int a = 0; a < DEPTH; a++) do_read("t4_rd", a);

        // clear from FULL (IDLE in loop build); held rec_en must not re-arm
        clear = 1'b1;
        step();
        clear = 1'b0;
        model_start();
        chk("t5_clear_length", length, 0);
        chk("t5_clear_full", full, 0);
        chk("t5_clear_recording", recording, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t5_no_rearm", recording, 0);
            chk("t5_no_strobe", wr_strobe, 0);
        end
        do_read("t5_rd0", 0);

        // clear ignored while recording, then reset mid-take
        rec_en = 1'b0;
        step();
        data_x = 16'h11; data_y = 16'h22; data_z = 16'h33;
        rec_en = 1'b1;
        model_start();
        for (int k = 1; k <= 10; k++) begin
            if (k == 10) clear = 1'b1;
            step();
            se = (k == 5) || (k == 9);
            if (se) model_write(data_x, data_y, data_z);
            chk("t5_rec_strobe", wr_strobe, se);
            chk("t5_rec_length", length, exp_len);
            chk("t5_rec_recording", recording, 1);
        end
        clear = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        exp_len = 0;
        waddr = 0;
        chk("t6_rst_length", length, 0);
        chk("t6_rst_recording", recording, 0);
        chk("t6_rst_valid", rd_valid, 0);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("t6_held_idle", recording, 0);
            chk("t6_held_strobe", wr_strobe, 0);
        end
        do_read("t6_rd0", 0);

        // edge beats clear; read-before-write on the address being written
        rec_en = 1'b0;
        step();
        data_x = 16'h44; data_y = 16'h55; data_z = 16'h66;
        rd_addr = '0;
        rec_en = 1'b1;
        clear = 1'b1;
        model_start();
        step();
        clear = 1'b0;
        chk("t7_edge_wins", recording, 1);
        chk("t7_len", length, 0);
        for (int k = 2; k <= 4; k++) begin
            step();
            chk("t7_pre_strobe", wr_strobe, 0);
        end
        push_rd("t7_rbw", 1'b0, 1'b1, mx[0], my[0], mz[0]);
        step();
        pop_rd();
        chk("t7_strobe", wr_strobe, 1);
        model_write(data_x, data_y, data_z);
        chk("t7_len1", length, exp_len);
        push_rd("t7_new", 1'b1, 1'b1, mx[0], my[0], mz[0]);
        step();
        pop_rd();
        rec_en = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
